sm4_key_sched_ctrl: RTL and testbench
=====================================

# sm4_key_sched_ctrl

Round-key schedule controller for the SM4 core. It accepts a 128-bit master key and drives the single-round key-extension datapath through rounds 0..31, holding round index and key state stable for each round. It feeds each returned 128-bit state back as the next round's input and stores the 32 round keys in an internal buffer. The encrypt/decrypt round engine reads keys from that buffer in forward or reverse order.

## Interface
Parameters:
- TIMEOUT, 16: max cycles spent in WAIT for one round before abort (range 2..255).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_key_start  in  1  one-cycle start request; honoured only in IDLE.
- i_key  in  128  master key MK0..MK3, MK0 in [127:96]; sampled with i_key_start.
- o_busy  out  1  high in ISSUE/WAIT/DONE.
- o_keys_ready  out  1  all 32 round keys valid.
- o_done  out  1  one-cycle pulse when schedule completes.
- o_err  out  1  sticky timeout flag; cleared by next accepted start or reset.
- o_ke_round  out  8  round index to datapath (0..31).
- o_ke_key  out  128  128-bit key state to datapath.
- o_ke_valid  out  1  one-cycle launch strobe to datapath.
- i_ke_rk  in  32  round key from datapath.
- i_ke_state  in  128  next key state {K1,K2,K3,rk} from datapath; aligned with i_ke_rk.
- i_ke_rk_valid  in  1  datapath result strobe.
- i_rk_rd_idx  in  5  round-key read index.
- i_rk_rd_dec  in  1  1 = decrypt order (returns rk[31-idx]).
- o_rk_rd_data  out  32  registered read data, 1-cycle latency.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE + i_key_start: latch i_key into the state register, round:=0, clear o_keys_ready and o_err, go to ISSUE.
- ISSUE: o_ke_valid=1 for exactly one cycle, wait counter:=0, go to WAIT.
- WAIT + i_ke_rk_valid:
  - buf[round] := i_ke_rk; state register := i_ke_state.
  - If round==31, go to DONE; else round:=round+1 and go to ISSUE.
- WAIT without valid: counter increments. When counter reaches TIMEOUT-1 with no valid: set o_err, go to IDLE; o_keys_ready stays 0.
- DONE: o_done=1, o_keys_ready:=1, go to IDLE.
- o_ke_key = state register: the master key in round 0 (the datapath applies FK when round==0), the fed-back state thereafter.
- o_ke_round and o_ke_key are held constant from ISSUE through the capture cycle in WAIT. The datapath requires both stable for the whole round.
- i_ke_rk_valid outside WAIT is ignored; the buffer and state are unchanged.
- i_key_start outside IDLE is ignored; the running schedule continues and o_err is not set.
- Read port works in any state; read address = i_rk_rd_dec ? 31-idx : idx. Data is meaningful only while o_keys_ready=1.
- Buffer: 32x32 registers, written only in WAIT on a valid capture; not cleared by reset.

## Timing
- Reset values: FSM=IDLE, round=0, o_busy=0, o_keys_ready=0, o_done=0, o_err=0, o_ke_valid=0, o_ke_round=0, o_ke_key=0, o_rk_rd_data=0.
- All outputs are registered.
- Start accepted in cycle T → o_ke_valid high in T+1 with o_ke_round=0, o_ke_key=MK.
- Datapath latency L (nominally 4) means i_ke_rk_valid arrives L cycles after o_ke_valid.
- Round k launch at cycle T+1+(L+1)k; per-round period L+1.
- Final capture at T+32(L+1); o_done and o_keys_ready rise at T+1+32(L+1). For L=4 this is T+161.
- o_busy rises at T+1 and falls the cycle after o_done.
- Reset mid-schedule returns to IDLE next edge with o_keys_ready=0; a restart after reset runs from round 0.
- A valid arriving in the same cycle the timeout fires: the capture wins and no error is raised.

## Test plan
- Key 0123456789ABCDEFFEDCBA9876543210 with a behavioural datapath (L=4) → buf[0]=F12186F9, buf[31]=9124A012, o_done at start+161, o_keys_ready=1.
- After the previous run, read idx=0 with dec=1 → o_rk_rd_data=9124A012 one cycle later; idx=31, dec=0 → 9124A012; idx=31, dec=1 → F12186F9.
- Pulse i_key_start at round 10 with a different key → ignored; final keys match the first key; exactly one o_done.
- Datapath withholds valid at round 5 (TIMEOUT=16) → o_err=1 sixteen cycles after that round's WAIT entry, FSM IDLE, o_keys_ready=0; next start clears o_err and completes.
- i_rst asserted for 1 cycle at round 20 → next cycle all outputs at reset values; restart produces the vector-1 keys.
- Spurious i_ke_rk_valid in IDLE and ISSUE cycles → no buffer writes, no round advance; round keys unchanged.

Source files
------------

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 round-key schedule controller.
// Drives a single-round key-extension datapath through rounds 0..31. The
// returned key state is fed back as the next round's input, and each round
// key is stored in a 32-entry buffer. The buffer can be read in encrypt
// order (idx) or decrypt order (31-idx).
module sm4_key_sched_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_key_start,
  input  logic [127:0] i_key,
  output logic         o_busy,
  output logic         o_keys_ready,
  output logic         o_done,
  output logic         o_err,
  output logic [7:0]   o_ke_round,
  output logic [127:0] o_ke_key,
  output logic         o_ke_valid,
  input  logic [31:0]  i_ke_rk,
  input  logic [127:0] i_ke_state,
  input  logic         i_ke_rk_valid,
  input  logic [4:0]   i_rk_rd_idx,
  input  logic         i_rk_rd_dec,
  output logic [31:0]  o_rk_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  round;
  logic [7:0]  wait_cnt;
  logic        start_acc;
  logic        capture;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rk_buf [32];

  assign o_ke_round = {3'b000, round};
  assign rd_addr    = i_rk_rd_dec ? (5'd31 - i_rk_rd_idx) : i_rk_rd_idx;

  // Next-state decode; a capture in the last WAIT cycle beats the timeout.
  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (i_key_start) begin
          start_acc = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (i_ke_rk_valid) begin
          capture  = 1'b1;
          state_nx = (round == 5'd31) ? DONE : ISSUE;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Round index, key state, wait counter and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      round        <= 5'd0;
      wait_cnt     <= 8'd0;
      o_busy       <= 1'b0;
      o_keys_ready <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_ke_valid   <= 1'b0;
      o_ke_key     <= 128'd0;
    end else begin
      o_busy     <= (state_nx != IDLE);
      o_done     <= (state_nx == DONE);
      o_ke_valid <= (state_nx == ISSUE);
      if (state == ISSUE)     wait_cnt <= 8'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (start_acc) begin
        o_ke_key     <= i_key;
        round        <= 5'd0;
        o_keys_ready <= 1'b0;
        o_err        <= 1'b0;
      end
      if (capture) begin
        o_ke_key <= i_ke_state;
        if (round != 5'd31) round <= round + 5'd1;
      end
      if (abort)              o_err        <= 1'b1;
      if (state_nx == DONE)   o_keys_ready <= 1'b1;
    end
  end

  // Round-key buffer: written only on a capture, never cleared.
  always_ff @(posedge i_clk) begin
    if (capture) rk_buf[round] <= i_ke_rk;
  end

  // Registered read port with optional reversed (decrypt) addressing.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_rk_rd_data <= 32'd0;
    else       o_rk_rd_data <= rk_buf[rd_addr];
  end

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Directed testbench for sm4_key_sched_ctrl with a behavioural SM4
// key-extension datapath (latency 4) driven from the stimulus thread.
module tb_sm4_key_sched_ctrl;
  localparam int TO  = 16;
  localparam int LAT = 4;
  localparam logic [127:0] FK = 128'hA3B1BAC656AA3350677D9197B27022DC;
  localparam logic [127:0] K1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] K2 = 128'hFEDCBA98765432100123456789ABCDEF;
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  logic         i_clk;
  logic         i_rst;
  logic         i_key_start;
  logic [127:0] i_key;
  logic         o_busy, o_keys_ready, o_done, o_err, o_ke_valid;
  logic [7:0]   o_ke_round;
  logic [127:0] o_ke_key;
  logic [31:0]  i_ke_rk;
  logic [127:0] i_ke_state;
  logic         i_ke_rk_valid;
  logic [4:0]   i_rk_rd_idx;
  logic         i_rk_rd_dec;
  logic [31:0]  o_rk_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tstart = 0;
  int dp_cnt = 0;
  bit dp_pend = 0;
  logic [4:0]   dp_round;
  logic [127:0] dp_key;
  logic [31:0]  dp_rk;
  logic [127:0] dp_state;
  int drop_round = -1;
  int slow_round = -1;
  int spur_round = -1;
  bit spur_now = 0;
  logic [31:0] exp_rk [32];

  sm4_key_sched_ctrl #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_key_start(i_key_start), .i_key(i_key),
    .o_busy(o_busy), .o_keys_ready(o_keys_ready), .o_done(o_done), .o_err(o_err),
    .o_ke_round(o_ke_round), .o_ke_key(o_ke_key), .o_ke_valid(o_ke_valid),
    .i_ke_rk(i_ke_rk), .i_ke_state(i_ke_state), .i_ke_rk_valid(i_ke_rk_valid),
    .i_rk_rd_idx(i_rk_rd_idx), .i_rk_rd_dec(i_rk_rd_dec), .o_rk_rd_data(o_rk_rd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8 * int'(a) -: 8];
  endfunction

  function automatic logic [31:0] ck(input int i);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < 4; j++) r[31 - 8 * j -: 8] = 8'(((4 * i + j) * 7) % 256);
    return r;
  endfunction

  function automatic logic [31:0] tkey(input logic [31:0] x);
    logic [31:0] b;
    b = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  task automatic sm4_round(input logic [4:0] r, input logic [127:0] kin,
                           output logic [31:0] rk, output logic [127:0] st);
    logic [127:0] k;
    k  = (r == 5'd0) ? (kin ^ FK) : kin;
    rk = k[127:96] ^ tkey(k[95:64] ^ k[63:32] ^ k[31:0] ^ ck(int'(r)));
    st = {k[95:0], rk};
  endtask

  task automatic gen_exp(input logic [127:0] mk);
    logic [127:0] k, kn;
    logic [31:0]  rk;
    k = mk;
    for (int i = 0; i < 32; i++) begin
      sm4_round(5'(i), k, rk, kn);
      exp_rk[i] = rk;
      k = kn;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural datapath, evaluated once per cycle at the falling edge.
  task automatic dp_tick();
    i_ke_rk_valid = 1'b0;
    if (i_rst) dp_pend = 0;
    if (dp_pend) begin
      dp_cnt--;
      if (dp_cnt == 0) begin
        dp_pend = 0;
        chk("ke_round_hold", 128'(o_ke_round), 128'(dp_round));
        chk("ke_key_hold", o_ke_key, dp_key);
        i_ke_rk = dp_rk;
        i_ke_state = dp_state;
        i_ke_rk_valid = 1'b1;
      end
    end
    if (o_ke_valid) begin
      dp_round = o_ke_round[4:0];
      dp_key = o_ke_key;
      sm4_round(dp_round, dp_key, dp_rk, dp_state);
      if (int'(dp_round) == spur_round) begin
        i_ke_rk = 32'hDEADBEEF;
        i_ke_state = {4{32'hA5A5A5A5}};
        i_ke_rk_valid = 1'b1;
      end
      if (int'(dp_round) != drop_round) begin
        dp_pend = 1;
        dp_cnt = (int'(dp_round) == slow_round) ? TO : LAT;
      end
    end
    if (spur_now) begin
      i_ke_rk = 32'hDEADBEEF;
      i_ke_state = {4{32'h5A5A5A5A}};
      i_ke_rk_valid = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    cyc++;
    dp_tick();
  endtask

  task automatic do_start(input logic [127:0] mk);
    i_key = mk;
    i_key_start = 1'b1;
    tstart = cyc;
    step();
    i_key_start = 1'b0;
    chk("launch_valid", 128'(o_ke_valid), 128'd1);
    chk("launch_round", 128'(o_ke_round), 128'd0);
    chk("launch_key", o_ke_key, mk);
    chk("launch_busy", 128'(o_busy), 128'd1);
    chk("launch_err_clr", 128'(o_err), 128'd0);
    chk("launch_rdy_clr", 128'(o_keys_ready), 128'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 128'(o_done), 128'd1);
    chk({tag, "_cycle"}, 128'(cyc - tstart), 128'd161);
    chk({tag, "_ready"}, 128'(o_keys_ready), 128'd1);
    chk({tag, "_err"}, 128'(o_err), 128'd0);
  endtask

  task automatic wait_launch(input int r, input string tag);
    int n = 0;
    while (!(o_ke_valid && o_ke_round == 8'(r)) && n < 400) begin
      step();
      n++;
    end
    chk(tag, 128'(o_ke_valid && o_ke_round == 8'(r)), 128'd1);
  endtask

  task automatic rd(input int idx, input logic dec, input logic [31:0] exp, input string tag);
    i_rk_rd_idx = 5'(idx);
    i_rk_rd_dec = dec;
    step();
    chk(tag, 128'(o_rk_rd_data), 128'(exp));
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 32; i++) rd(i, 1'b0, exp_rk[i], tag);
  endtask

  initial begin
    int dones;
    logic [127:0] last_state;
    i_rst = 1'b1; i_key_start = 1'b0; i_key = 128'd0;
    i_ke_rk = 32'd0; i_ke_state = 128'd0; i_ke_rk_valid = 1'b0;
    i_rk_rd_idx = 5'd0; i_rk_rd_dec = 1'b0;
    repeat (3) step();
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_ready", 128'(o_keys_ready), 128'd0);
    chk("rst_done", 128'(o_done), 128'd0);
    chk("rst_err", 128'(o_err), 128'd0);
    chk("rst_valid", 128'(o_ke_valid), 128'd0);
    chk("rst_round", 128'(o_ke_round), 128'd0);
    chk("rst_key", o_ke_key, 128'd0);
    chk("rst_rd", 128'(o_rk_rd_data), 128'd0);
    i_rst = 1'b0;
    step();

    // Run 1: reference vector.
    gen_exp(K1);
    do_start(K1);
    wait_done("run1_done");
    last_state = dp_state;
    step();
    chk("run1_busy_fall", 128'(o_busy), 128'd0);
    chk("run1_done_pulse", 128'(o_done), 128'd0);
    chk("run1_ready_hold", 128'(o_keys_ready), 128'd1);
    rd(0, 1'b0, 32'hF12186F9, "rk0_enc");
    rd(0, 1'b1, 32'h9124A012, "rk0_dec");
    rd(31, 1'b0, 32'h9124A012, "rk31_enc");
    rd(31, 1'b1, 32'hF12186F9, "rk31_dec");
    rd(3, 1'b1, exp_rk[28], "rk3_dec");
    check_buf("run1_buf");

    // Spurious result strobe while idle.
    spur_now = 1;
    step();
    spur_now = 0;
    step();
    chk("spur_idle_busy", 128'(o_busy), 128'd0);
    chk("spur_idle_round", 128'(o_ke_round), 128'd31);
    chk("spur_idle_key", o_ke_key, last_state);
    check_buf("spur_idle_buf");

    // Run 2: ignored start at round 10, spurious strobe in ISSUE of round 7,
    // and a round-3 result landing in the very last WAIT cycle.
    spur_round = 7;
    slow_round = 3;
    do_start(K1);
    wait_launch(10, "run2_round10");
    i_key = K2;
    i_key_start = 1'b1;
    step();
    i_key_start = 1'b0;
    chk("run2_start_ignored", 128'(o_busy), 128'd1);
    dones = 0;
    for (int n = 0; n < 250; n++) begin
      step();
      if (o_done) dones++;
    end
    spur_round = -1;
    slow_round = -1;
    chk("run2_one_done", 128'(dones), 128'd1);
    chk("run2_ready", 128'(o_keys_ready), 128'd1);
    chk("run2_no_err", 128'(o_err), 128'd0);
    check_buf("run2_buf");

    // Run 3: datapath withholds round 5 -> timeout, then recovery with K2.
    drop_round = 5;
    do_start(K1);
    wait_launch(5, "run3_round5");
    tstart = cyc;
    repeat (16) step();
    chk("to_err_early", 128'(o_err), 128'd0);
    chk("to_busy_early", 128'(o_busy), 128'd1);
    step();
    chk("to_err_set", 128'(o_err), 128'd1);
    chk("to_busy_clr", 128'(o_busy), 128'd0);
    chk("to_ready_clr", 128'(o_keys_ready), 128'd0);
    repeat (6) step();
    chk("to_idle_novalid", 128'(o_ke_valid), 128'd0);
    chk("to_err_sticky", 128'(o_err), 128'd1);
    drop_round = -1;
    gen_exp(K2);
    do_start(K2);
    wait_done("run3_done");
    check_buf("run3_buf");

    // Run 4: reset at round 20, then restart with the reference key.
    gen_exp(K1);
    do_start(K1);
    wait_launch(20, "run4_round20");
    i_rst = 1'b1;
    step();
    chk("mrst_busy", 128'(o_busy), 128'd0);
    chk("mrst_ready", 128'(o_keys_ready), 128'd0);
    chk("mrst_done", 128'(o_done), 128'd0);
    chk("mrst_err", 128'(o_err), 128'd0);
    chk("mrst_valid", 128'(o_ke_valid), 128'd0);
    chk("mrst_round", 128'(o_ke_round), 128'd0);
    chk("mrst_key", o_ke_key, 128'd0);
    chk("mrst_rd", 128'(o_rk_rd_data), 128'd0);
    i_rst = 1'b0;
    repeat (10) step();
    do_start(K1);
    wait_done("run4_done");
    rd(0, 1'b0, 32'hF12186F9, "run4_rk0");
    rd(31, 1'b0, 32'h9124A012, "run4_rk31");
    check_buf("run4_buf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
